// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the RAM bus arbiter slice.
package bus_arb_pkg;

  // Arbiter ownership states. The fourth encoding is unused and recovers to idle.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // Master identifiers as used by the "last served" register and the picker.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // One-hot grant vector for a given ownership state (bit0 = m0, bit1 = m1).
  function automatic logic [1:0] gntFromState(input arb_state_e state);
    logic [1:0] gnt;
    case (state)
      ARB_OWN0: gnt = 2'b01;
      ARB_OWN1: gnt = 2'b10;
      default:  gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie, the master that was not served last wins.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner,
  output logic       o_valid
);

  // Combinational pick: a lone requester wins outright, a tie goes to the other master.
  always_comb begin
    o_valid  = |i_req;
    o_winner = M0;
    if (i_req == 2'b11) begin
      o_winner = ~i_last;
    end else if (i_req[1]) begin
      o_winner = M1;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares the single-port data RAM bus between the CPU data port (m0) and the
// DMA/debug loader (m1) with per-transfer round-robin and a bounded lock.
module ram_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wData,
  output logic [DATA_W-1:0] m0_rData,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wData,
  output logic [DATA_W-1:0] m1_rData,
  output logic              m1_ready,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWData,
  input  logic [DATA_W-1:0] busRData,
  output logic [1:0]        gnt
);

  localparam int LOCK_W = $clog2(MAX_LOCK + 1);
  // The owner may stay while lock_cnt is below this, giving at most MAX_LOCK
  // consecutive transfers while the other master waits.
  localparam logic [LOCK_W-1:0] LOCK_LIMIT = LOCK_W'(MAX_LOCK - 1);

  arb_state_e        r_state;
  arb_state_e        w_nextState;
  logic              r_last;
  logic              w_nextLast;
  logic [LOCK_W-1:0] r_lockCnt;
  logic [LOCK_W-1:0] w_nextLockCnt;

  logic w_pickWinner;
  logic w_pickValid;
  logic w_owner;
  logic w_ownReq;
  logic w_otherReq;
  logic w_ownLock;
  logic w_xfer;

  rr_pick2 u_pick (
    .i_req    ({m1_req, m0_req}),
    .i_last   (r_last),
    .o_winner (w_pickWinner),
    .o_valid  (w_pickValid)
  );

  // Resolve owner-relative views of the request lines and whether a transfer happens now.
  always_comb begin
    w_owner    = (r_state == ARB_OWN1);
    w_ownReq   = w_owner ? m1_req  : m0_req;
    w_otherReq = w_owner ? m0_req  : m1_req;
    w_ownLock  = w_owner ? m1_lock : m0_lock;
    w_xfer     = (r_state == ARB_OWN0 || r_state == ARB_OWN1) && w_ownReq && !reset;
  end

  // State, last-served and lock-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_last    <= M1;
      r_lockCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_last    <= w_nextLast;
      r_lockCnt <= w_nextLockCnt;
    end
  end

  // Next-state: arbitrate from idle, then keep, hand over or release after each owned cycle.
  always_comb begin
    w_nextState   = r_state;
    w_nextLast    = r_last;
    w_nextLockCnt = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pickValid) begin
          w_nextState = w_pickWinner ? ARB_OWN1 : ARB_OWN0;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (w_ownReq) begin
          w_nextLast = w_owner;
          if (w_ownLock && w_otherReq && (r_lockCnt < LOCK_LIMIT)) begin
            w_nextLockCnt = r_lockCnt + 1'b1;
          end else if (w_otherReq) begin
            w_nextState = w_owner ? ARB_OWN0 : ARB_OWN1;
          end
          // Otherwise the owner still requests and keeps the bus with lock_cnt cleared.
        end else begin
          // Owner withdrew: no transfer, hand over or fall back to idle.
          w_nextState = w_otherReq ? (w_owner ? ARB_OWN0 : ARB_OWN1) : ARB_IDLE;
        end
      end
      default: w_nextState = ARB_IDLE;
    endcase
  end

  // Outputs: route the owner onto the RAM bus only in a transfer cycle, zero otherwise.
  always_comb begin
    gnt      = reset ? 2'b00 : gntFromState(r_state);
    busWe    = 1'b0;
    busAddr  = '0;
    busWData = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rData = '0;
    m1_rData = '0;
    if (w_xfer) begin
      if (w_owner) begin
        busWe    = m1_we;
        busAddr  = m1_addr;
        busWData = m1_wData;
        m1_ready = 1'b1;
        m1_rData = busRData;
      end else begin
        busWe    = m0_we;
        busAddr  = m0_addr;
        busWData = m0_wData;
        m0_ready = 1'b1;
        m0_rData = busRData;
      end
    end
  end

endmodule
